// File: rtl/scan_pkg.sv
// Shared definitions for the Larson scanner step counter.
//
// Contents:
//   SCAN_WIDTH_DEF - default counter width
//   SCAN_DIV_DEF   - default prescaler divisor
//   scan_pos_t     - scan position type at the default width
//   scan_max()     - all-ones value for a given width (width <= 32)
package scan_pkg;

   localparam int unsigned SCAN_WIDTH_DEF = 4;
   localparam int unsigned SCAN_DIV_DEF   = 1000;

   typedef logic [SCAN_WIDTH_DEF-1:0] scan_pos_t;

   function automatic logic [31:0] scan_max(input int unsigned width);
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < 32; i++) begin
         if (i < int'(width)) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/scan_step_counter_prescaler.sv
// scan_prescaler: divide-by-DIV clock-enable generator for the scan counter.
//
// Ports:
//   i_clk      system clock
//   i_rst_n    asynchronous active-low reset
//   i_en       count enable; low freezes the phase
//   i_restart  synchronous phase restart (clear or load in the counter)
//   o_pulse    combinational strobe, high on the last phase while enabled
//   o_tick     o_pulse registered, one cycle wide
module scan_prescaler #(
   parameter int unsigned DIV   = 1000,
   parameter int unsigned DIV_W = 10
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_en,
   input  logic i_restart,
   output logic o_pulse,
   output logic o_tick
);

   localparam logic [DIV_W-1:0] PreLast = DIV_W'(DIV - 1);

   logic [DIV_W-1:0] pre_q, pre_d;
   logic             tick_q;

   assign o_pulse = i_en & (pre_q == PreLast);
   assign o_tick  = tick_q;

   always_comb begin
      pre_d = pre_q;
      if (i_restart) begin
         pre_d = '0;
      end else if (i_en) begin
         pre_d = (pre_q == PreLast) ? '0 : pre_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pre_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         pre_q  <= pre_d;
         tick_q <= o_pulse;
      end
   end

endmodule

// File: rtl/scan_step_counter.sv
// scan_step_counter: presettable binary counter behind a clock prescaler, producing the
// slow scan position for the Larson scanner (the fold stage XORs low bits with the MSB).
//
// Optional feature: define SCAN_STEP_COUNTER_UPDOWN_EN to add i_up (1 = up, 0 = down).
//
// Ports:
//   i_clk     system clock
//   i_rst_n   asynchronous active-low reset
//   i_en      count enable; low freezes prescaler and counter
//   i_clr_n   synchronous clear, active low (highest priority)
//   i_load_n  synchronous parallel load, active low
//   i_d       parallel load data
//   i_up      count direction (only with SCAN_STEP_COUNTER_UPDOWN_EN)
//   o_q       registered counter value
//   o_tick    registered one-cycle prescaler strobe
//   o_tc      combinational terminal count
//   o_wrap    registered one-cycle pulse after the counter wraps
module scan_step_counter
   import scan_pkg::*;
#(
   parameter  int unsigned WIDTH = SCAN_WIDTH_DEF,
   parameter  int unsigned DIV   = SCAN_DIV_DEF,
   localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic             i_clr_n,
   input  logic             i_load_n,
   input  logic [WIDTH-1:0] i_d,
`ifdef SCAN_STEP_COUNTER_UPDOWN_EN
   input  logic             i_up,
`endif
   output logic [WIDTH-1:0] o_q,
   output logic             o_tick,
   output logic             o_tc,
   output logic             o_wrap
);

   localparam logic [WIDTH-1:0] MaxVal = WIDTH'(scan_max(WIDTH));

   logic [WIDTH-1:0] q_q, q_d;
   logic             wrap_q, wrap_d;
   logic             pulse;
   logic             restart;
   logic             up;
   logic             at_end;

`ifdef SCAN_STEP_COUNTER_UPDOWN_EN
   assign up = i_up;
`else
   assign up = 1'b1;
`endif

   assign restart = ~i_clr_n | ~i_load_n;

   scan_prescaler #(
      .DIV   (DIV),
      .DIV_W (DIV_W)
   ) u_prescaler (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_en      (i_en),
      .i_restart (restart),
      .o_pulse   (pulse),
      .o_tick    (o_tick)
   );

   // Terminal value depends on direction: all ones going up, zero going down.
   assign at_end = up ? (q_q == MaxVal) : (q_q == '0);
   assign o_tc   = i_en & at_end;

   always_comb begin
      q_d    = q_q;
      wrap_d = 1'b0;
      if (!i_clr_n) begin
         q_d = '0;
      end else if (!i_load_n) begin
         q_d = i_d;
      end else if (pulse) begin
         q_d    = up ? q_q + 1'b1 : q_q - 1'b1;
         wrap_d = at_end;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         q_q    <= '0;
         wrap_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         wrap_q <= wrap_d;
      end
   end

   assign o_q    = q_q;
   assign o_wrap = wrap_q;

endmodule

// File: tb/tb_scan_step_counter.sv
module tb_scan_step_counter;

   localparam int unsigned W = 4;
   localparam int unsigned D = 4;

   typedef struct {
      logic [W-1:0] q;
      logic         tick;
      logic         wrap;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         en, clr_n, load_n;
   logic [W-1:0] d;
   logic [W-1:0] q;
   logic         tick, tc, wrap;

   int           n_tests = 0;
   int           n_fail  = 0;
   exp_t         sb[$];

   // Reference model state
   logic [W-1:0] m_q;
   int           m_pre;

   scan_step_counter #(
      .WIDTH (W),
      .DIV   (D)
   ) dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_en     (en),
      .i_clr_n  (clr_n),
      .i_load_n (load_n),
      .i_d      (d),
`ifdef SCAN_STEP_COUNTER_UPDOWN_EN
      .i_up     (1'b1),
`endif
      .o_q      (q),
      .o_tick   (tick),
      .o_tc     (tc),
      .o_wrap   (wrap)
   );

`ifdef SCAN_STEP_COUNTER_UPDOWN_EN
   logic         en1, clr1_n, load1_n, up1;
   logic [W-1:0] d1, q1;
   logic         tick1, tc1, wrap1;

   scan_step_counter #(
      .WIDTH (W),
      .DIV   (1)
   ) dut1 (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_en     (en1),
      .i_clr_n  (clr1_n),
      .i_load_n (load1_n),
      .i_d      (d1),
      .i_up     (up1),
      .o_q      (q1),
      .o_tick   (tick1),
      .o_tc     (tc1),
      .o_wrap   (wrap1)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: check o_tc, predict the edge, push, clock, pop and compare.
   task automatic cyc();
      exp_t e;
      logic pulse;
      #1;
      chk("tc", {31'b0, tc}, {31'b0, en && (m_q == 4'hF)});
      pulse  = en && (m_pre == int'(D) - 1);
      e.tick = pulse;
      e.wrap = 1'b0;
      if (!clr_n) begin
         e.q   = '0;
         m_pre = 0;
      end else if (!load_n) begin
         e.q   = d;
         m_pre = 0;
      end else begin
         if (pulse) begin
            e.q    = m_q + 1'b1;
            e.wrap = (m_q == 4'hF);
         end else begin
            e.q = m_q;
         end
         if (en) m_pre = (m_pre == int'(D) - 1) ? 0 : m_pre + 1;
      end
      m_q = e.q;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("q", {28'b0, q}, {28'b0, e.q});
      chk("tick", {31'b0, tick}, {31'b0, e.tick});
      chk("wrap", {31'b0, wrap}, {31'b0, e.wrap});
   endtask

   // Asynchronous reset applied between edges; outputs must clear with no edge.
   task automatic do_reset();
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_q", {28'b0, q}, 32'h0);
      chk("rst_tick", {31'b0, tick}, 32'h0);
      chk("rst_wrap", {31'b0, wrap}, 32'h0);
      m_q   = '0;
      m_pre = 0;
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int ticks;
      int wraps;
      rst_n  = 1'b0;
      en     = 1'b0;
      clr_n  = 1'b1;
      load_n = 1'b1;
      d      = '0;
      m_q    = '0;
      m_pre  = 0;
`ifdef SCAN_STEP_COUNTER_UPDOWN_EN
      en1     = 1'b0;
      clr1_n  = 1'b1;
      load1_n = 1'b1;
      up1     = 1'b1;
      d1      = '0;
`endif
      #3;
      chk("init_q", {28'b0, q}, 32'h0);
      chk("init_tick", {31'b0, tick}, 32'h0);
      chk("init_wrap", {31'b0, wrap}, 32'h0);
      chk("init_tc", {31'b0, tc}, 32'h0);
      rst_n = 1'b1;

      // Free run for 64 cycles: 16 ticks, one full lap, a single wrap.
      en    = 1'b1;
      ticks = 0;
      wraps = 0;
      for (int i = 0; i < 64; i++) begin
         cyc();
         ticks += int'(tick);
         wraps += int'(wrap);
      end
      chk("run_ticks", ticks, 16);
      chk("run_wraps", wraps, 1);
      chk("run_q_end", {28'b0, q}, 32'h0);

      // Parallel load of 14 at count 5, then the next step needs a full phase.
      do_reset();
      for (int i = 0; i < 20; i++) cyc();
      chk("pre_load_q", {28'b0, q}, 32'h5);
      load_n = 1'b0;
      d      = 4'hE;
      cyc();
      load_n = 1'b1;
      chk("load_q", {28'b0, q}, 32'hE);
      for (int i = 0; i < 3; i++) cyc();
      chk("load_hold_q", {28'b0, q}, 32'hE);
      cyc();
      chk("load_step_q", {28'b0, q}, 32'hF);

      // Clear and load together on a pulse cycle at 9: clear wins, no wrap.
      do_reset();
      for (int i = 0; i < 39; i++) cyc();
      chk("pre_clr_q", {28'b0, q}, 32'h9);
      clr_n  = 1'b0;
      load_n = 1'b0;
      d      = 4'h5;
      cyc();
      clr_n  = 1'b1;
      load_n = 1'b1;
      chk("clr_q", {28'b0, q}, 32'h0);
      chk("clr_wrap", {31'b0, wrap}, 32'h0);

      // Freeze at 3 with phase 2, then resume where it stopped.
      do_reset();
      for (int i = 0; i < 14; i++) cyc();
      en = 1'b0;
      for (int i = 0; i < 10; i++) cyc();
      chk("frz_q", {28'b0, q}, 32'h3);
      chk("frz_tick", {31'b0, tick}, 32'h0);
      chk("frz_tc", {31'b0, tc}, 32'h0);
      en = 1'b1;
      cyc();
      chk("res1_q", {28'b0, q}, 32'h3);
      cyc();
      chk("res2_q", {28'b0, q}, 32'h4);

      // Asynchronous reset mid-count at 11, then a full phase before the first step.
      do_reset();
      for (int i = 0; i < 44; i++) cyc();
      chk("pre_rst_q", {28'b0, q}, 32'hB);
      do_reset();
      for (int i = 0; i < 3; i++) cyc();
      chk("post_rst_q", {28'b0, q}, 32'h0);
      cyc();
      chk("post_rst_step", {28'b0, q}, 32'h1);
      en = 1'b0;

`ifdef SCAN_STEP_COUNTER_UPDOWN_EN
      // Down count with DIV=1 from 1: 1, 0, 15, 14.
      load1_n = 1'b0;
      d1      = 4'h1;
      @(posedge clk);
      #1;
      load1_n = 1'b1;
      chk("dn_load_q", {28'b0, q1}, 32'h1);
      en1 = 1'b1;
      up1 = 1'b0;
      #1;
      chk("dn_tc1", {31'b0, tc1}, 32'h0);
      @(posedge clk);
      #1;
      chk("dn_q0", {28'b0, q1}, 32'h0);
      chk("dn_tc0", {31'b0, tc1}, 32'h1);
      @(posedge clk);
      #1;
      chk("dn_q15", {28'b0, q1}, 32'hF);
      chk("dn_wrap", {31'b0, wrap1}, 32'h1);
      chk("dn_tc15", {31'b0, tc1}, 32'h0);
      @(posedge clk);
      #1;
      chk("dn_q14", {28'b0, q1}, 32'hE);
      chk("dn_wrap_end", {31'b0, wrap1}, 32'h0);
      en1 = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
